// File: rtl/ifft_seq_pkg.sv
// Shared types and constants for the IFFT frame sequencer.
// The optional conjugate-mirror lookup is enabled by the macro IFFT_SEQ_HERMITIAN_EN.
package ifft_seq_pkg;

    localparam int P_NFFT_LOG2 = 10;
    localparam int P_NTAB      = 8;
    localparam int P_AW        = 12;
    localparam int N           = 1 << P_NFFT_LOG2;

    // Config word for the IFFT core: bit0 = 0 selects the inverse transform
    localparam logic [7:0] CFG_INVERSE = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CFG    = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic                   en;
        logic [P_NFFT_LOG2-1:0] bin;
        logic signed [P_AW-1:0] re;
        logic signed [P_AW-1:0] im;
    } tab_entry_t;

    // Sign-extend one amplitude component to the 24-bit IFFT input lane
    function automatic logic [23:0] sext24(input logic [P_AW-1:0] v);
        return {{(24 - P_AW){v[P_AW-1]}}, v};
    endfunction

endpackage

// File: rtl/ifft_seq_bin_lookup.sv
// Parallel bin lookup: compares every harmonic table entry against the
// requested bin, lowest-indexed enabled match wins, result is registered.
// With IFFT_SEQ_HERMITIAN_EN defined, entries with 0 < bin < N/2 also answer
// for bin N-bin with the conjugate value; direct matches always win.
module ifft_seq_bin_lookup
    import ifft_seq_pkg::*;
#(
    parameter int NFFT_LOG2 = P_NFFT_LOG2,
    parameter int NTAB      = P_NTAB,
    parameter int AW        = P_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [NFFT_LOG2-1:0]  i_addr,
    input  tab_entry_t [NTAB-1:0] i_tab,
    output logic signed [AW-1:0]  o_re,
    output logic signed [AW-1:0]  o_im
);

    logic [NTAB-1:0]      w_direct;
    logic signed [AW-1:0] w_sel_re;
    logic signed [AW-1:0] w_sel_im;
    logic signed [AW-1:0] r_re;
    logic signed [AW-1:0] r_im;

    for (genvar gi = 0; gi < NTAB; gi++) begin : g_direct
        assign w_direct[gi] = i_tab[gi].en && (i_tab[gi].bin == i_addr);
    end

`ifdef IFFT_SEQ_HERMITIAN_EN
    logic [NTAB-1:0] w_mirror;

    for (genvar gi = 0; gi < NTAB; gi++) begin : g_mirror
        logic [NFFT_LOG2-1:0] w_mirror_bin;
        // N - bin, taken modulo N; only meaningful for bins in the lower half
        assign w_mirror_bin = ~i_tab[gi].bin + 1'b1;
        assign w_mirror[gi] = i_tab[gi].en
                           && (i_tab[gi].bin != '0)
                           && !i_tab[gi].bin[NFFT_LOG2-1]
                           && (w_mirror_bin == i_addr);
    end
`endif

    // Priority select: scan high to low so the lowest index is assigned last;
    // mirror hits are applied first so any direct hit overrides them
    always_comb begin
        w_sel_re = '0;
        w_sel_im = '0;
`ifdef IFFT_SEQ_HERMITIAN_EN
        for (int i = NTAB - 1; i >= 0; i--) begin
            if (w_mirror[i]) begin
                w_sel_re = i_tab[i].re;
                w_sel_im = -i_tab[i].im;
            end
        end
`endif
        for (int i = NTAB - 1; i >= 0; i--) begin
            if (w_direct[i]) begin
                w_sel_re = i_tab[i].re;
                w_sel_im = i_tab[i].im;
            end
        end
    end

    // Output register only moves on a load, which keeps tdata stable in stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_re <= '0;
            r_im <= '0;
        end else if (i_load) begin
            r_re <= w_sel_re;
            r_im <= w_sel_im;
        end
    end

    assign o_re = r_re;
    assign o_im = r_im;

endmodule

// File: rtl/ifft_frame_sequencer.sv
// Generates one frequency-domain frame per request for the xfft_1 IFFT core:
// config word on the cfg channel, then N bins on the data channel with tlast
// on bin N-1. Spectrum comes from a small harmonic table writable while idle.
// Optional macro IFFT_SEQ_HERMITIAN_EN adds conjugate mirroring in the lookup.
module ifft_frame_sequencer
    import ifft_seq_pkg::*;
#(
    parameter int NFFT_LOG2 = P_NFFT_LOG2,
    parameter int NTAB      = P_NTAB,
    parameter int AW        = P_AW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    continuous,
    input  logic                    tab_we,
    input  logic [$clog2(NTAB)-1:0] tab_addr,
    input  logic                    tab_en,
    input  logic [NFFT_LOG2-1:0]    tab_bin,
    input  logic signed [AW-1:0]    tab_re,
    input  logic signed [AW-1:0]    tab_im,
    output logic                    tab_err,
    output logic [7:0]              cfg_tdata,
    output logic                    cfg_tvalid,
    input  logic                    cfg_tready,
    output logic [47:0]             m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic                    busy,
    output logic                    frame_done
);

    localparam logic [NFFT_LOG2-1:0] LAST_BIN = NFFT_LOG2'(N - 1);

    state_t                r_state;
    logic [NFFT_LOG2-1:0]  r_bin;
    logic                  r_cfg_tvalid;
    logic                  r_m_tvalid;
    logic                  r_m_tlast;
    logic                  r_frame_done;
    logic                  r_tab_err;
    tab_entry_t [NTAB-1:0] r_tab;

    logic [NFFT_LOG2-1:0]  w_next_bin;
    logic [NFFT_LOG2-1:0]  w_lookup_addr;
    logic                  w_lookup_load;
    logic signed [AW-1:0]  w_re;
    logic signed [AW-1:0]  w_im;

    assign w_next_bin = r_bin + 1'b1;

    // Prefetch: bin 0 on the cfg handshake, then the following bin on each
    // data handshake, so the registered lookup keeps up with one beat per clk
    assign w_lookup_load = ((r_state == CFG) && cfg_tready)
                        || ((r_state == STREAM) && m_tready && !r_m_tlast);
    assign w_lookup_addr = (r_state == CFG) ? '0 : w_next_bin;

    // Frame sequencing: IDLE -> CFG -> STREAM -> DONE -> (CFG | IDLE)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bin        <= '0;
            r_cfg_tvalid <= 1'b0;
            r_m_tvalid   <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state      <= CFG;
                        r_cfg_tvalid <= 1'b1;
                    end
                end
                CFG: begin
                    if (cfg_tready) begin
                        r_state      <= STREAM;
                        r_cfg_tvalid <= 1'b0;
                        r_m_tvalid   <= 1'b1;
                        r_bin        <= '0;
                        r_m_tlast    <= 1'b0;
                    end
                end
                STREAM: begin
                    if (m_tready) begin
                        if (r_m_tlast) begin
                            r_state      <= DONE;
                            r_m_tvalid   <= 1'b0;
                            r_m_tlast    <= 1'b0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_bin     <= w_next_bin;
                            r_m_tlast <= (w_next_bin == LAST_BIN);
                        end
                    end
                end
                DONE: begin
                    if (continuous) begin
                        r_state      <= CFG;
                        r_cfg_tvalid <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Harmonic table: writable only while idle; busy writes are flagged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tab     <= '0;
            r_tab_err <= 1'b0;
        end else begin
            r_tab_err <= tab_we && (r_state != IDLE);
            if (tab_we && (r_state == IDLE)) begin
                r_tab[tab_addr] <= '{en: tab_en, bin: tab_bin, re: tab_re, im: tab_im};
            end
        end
    end

    ifft_seq_bin_lookup #(
        .NFFT_LOG2 (NFFT_LOG2),
        .NTAB      (NTAB),
        .AW        (AW)
    ) u_lookup (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_lookup_load),
        .i_addr (w_lookup_addr),
        .i_tab  (r_tab),
        .o_re   (w_re),
        .o_im   (w_im)
    );

    assign cfg_tdata  = CFG_INVERSE;
    assign cfg_tvalid = r_cfg_tvalid;
    assign m_tvalid   = r_m_tvalid;
    assign m_tlast    = r_m_tlast;
    assign m_tdata    = {sext24(w_im), sext24(w_re)};
    assign busy       = (r_state != IDLE);
    assign frame_done = r_frame_done;
    assign tab_err    = r_tab_err;

endmodule

// File: tb/tb_ifft_frame_sequencer.sv
// Self-checking bench for ifft_frame_sequencer. Expected frames come from a
// table model that applies the lookup rules directly per bin. Honours the
// IFFT_SEQ_HERMITIAN_EN macro in the model.
module tb_ifft_frame_sequencer;

    localparam int N    = 1024;
    localparam int NTAB = 8;

    logic        clk;
    logic        rst;
    logic        start;
    logic        continuous;
    logic        tab_we;
    logic [2:0]  tab_addr;
    logic        tab_en;
    logic [9:0]  tab_bin;
    logic signed [11:0] tab_re;
    logic signed [11:0] tab_im;
    logic        tab_err;
    logic [7:0]  cfg_tdata;
    logic        cfg_tvalid;
    logic        cfg_tready;
    logic [47:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference table
    int m_en [NTAB];
    int m_bin[NTAB];
    int m_re [NTAB];
    int m_im [NTAB];

    // Capture results
    logic [47:0] cap_data[N];
    logic        cap_last[N];
    int cap_n, cap_cfg_hs, cap_cfg_cnt, cap_first, cap_last_hs, cap_done;
    int cap_err_cnt, cap_err_cyc, cap_inj_cyc;

    // Values driven by an injected (busy) table write
    int inj_addr, inj_bin, inj_re, inj_im;

    ifft_frame_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .tab_we     (tab_we),
        .tab_addr   (tab_addr),
        .tab_en     (tab_en),
        .tab_bin    (tab_bin),
        .tab_re     (tab_re),
        .tab_im     (tab_im),
        .tab_err    (tab_err),
        .cfg_tdata  (cfg_tdata),
        .cfg_tvalid (cfg_tvalid),
        .cfg_tready (cfg_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [47:0] model_beat(input int k);
        int  re;
        int  im;
        bit  found;
        found = 0;
        re = 0;
        im = 0;
        for (int i = 0; i < NTAB; i++) begin
            if (!found && m_en[i] != 0 && m_bin[i] == k) begin
                re = m_re[i];
                im = m_im[i];
                found = 1;
            end
        end
`ifdef IFFT_SEQ_HERMITIAN_EN
        for (int i = 0; i < NTAB; i++) begin
            if (!found && m_en[i] != 0 && m_bin[i] > 0 && m_bin[i] < N / 2 && (N - m_bin[i]) == k) begin
                re = m_re[i];
                im = -m_im[i];
                found = 1;
            end
        end
`endif
        return {24'(im), 24'(re)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NTAB; i++) begin
            m_en[i] = 0; m_bin[i] = 0; m_re[i] = 0; m_im[i] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic write_entry(input int a, input int en, input int b, input int re, input int im);
        tab_addr = 3'(a);
        tab_en   = 1'(en);
        tab_bin  = 10'(b);
        tab_re   = 12'(re);
        tab_im   = 12'(im);
        tab_we   = 1'b1;
        @(negedge clk);
        tab_we = 1'b0;
        n_checks++;
        if (tab_err !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_write_err entry %0d: tab_err got %b exp 0", a, tab_err);
        end
        m_en[a] = en; m_bin[a] = b; m_re[a] = re; m_im[a] = im;
    endtask

    // Drive the channels of one frame and record every handshake until frame_done
    task automatic capture_frame(input int rdy_pct, input int cfg_hold, input int err_beat, input int clr_beat);
        int cyc;
        int cfg_wait;
        bit prev_stall;
        bit prev_cfg_stall;
        bit injected;
        logic [47:0] prev_data;
        logic prev_last;
        cyc = 0; cfg_wait = 0; prev_stall = 0; prev_cfg_stall = 0; injected = 0;
        prev_data = '0; prev_last = 1'b0;
        cap_n = 0; cap_cfg_hs = -1; cap_cfg_cnt = 0; cap_first = -1; cap_last_hs = -1;
        cap_done = -1; cap_err_cnt = 0; cap_err_cyc = -1; cap_inj_cyc = -1;
        while (cap_done < 0 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                n_checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last) begin
                    n_fail++;
                    $display("FAIL stall_stable cyc %0d: got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                             cyc, m_tvalid, m_tdata, m_tlast, prev_data, prev_last);
                end
            end
            if (prev_cfg_stall) begin
                n_checks++;
                if (cfg_tvalid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL cfg_stable cyc %0d: cfg_tvalid got %b exp 1", cyc, cfg_tvalid);
                end
            end
            if (tab_err === 1'b1) begin
                cap_err_cnt++;
                cap_err_cyc = cyc;
            end
            if (frame_done === 1'b1) cap_done = cyc;

            cfg_tready = cfg_tvalid && (cfg_wait >= cfg_hold);
            if (cfg_tvalid) cfg_wait++;
            m_tready = (int'($urandom_range(0, 99)) < rdy_pct);
            tab_we = 1'b0;
            if (err_beat >= 0 && !injected && cap_n == err_beat) begin
                tab_addr = 3'(inj_addr);
                tab_en   = 1'b1;
                tab_bin  = 10'(inj_bin);
                tab_re   = 12'(inj_re);
                tab_im   = 12'(inj_im);
                tab_we   = 1'b1;
                injected = 1;
                cap_inj_cyc = cyc;
            end
            if (clr_beat >= 0 && cap_n == clr_beat) continuous = 1'b0;

            if (cfg_tvalid && cfg_tready) begin
                cap_cfg_cnt++;
                cap_cfg_hs = cyc;
                n_checks++;
                if (cfg_tdata !== 8'h00) begin
                    n_fail++;
                    $display("FAIL cfg_word: got %h exp 00", cfg_tdata);
                end
            end
            if (m_tvalid === 1'b1 && cap_first < 0) cap_first = cyc;
            if (m_tvalid === 1'b1 && m_tready) begin
                if (cap_n < N) begin
                    cap_data[cap_n] = m_tdata;
                    cap_last[cap_n] = m_tlast;
                end
                cap_n++;
                if (m_tlast === 1'b1) cap_last_hs = cyc;
            end
            prev_stall     = (m_tvalid === 1'b1) && !m_tready;
            prev_cfg_stall = (cfg_tvalid === 1'b1) && !cfg_tready;
            prev_data      = m_tdata;
            prev_last      = m_tlast;
        end
        tab_we = 1'b0;
        m_tready = 1'b0;
        cfg_tready = 1'b0;
        n_checks++;
        if (cap_done < 0) begin
            n_fail++;
            $display("FAIL frame_timeout: frame_done not seen within %0d cycles, beats %0d", cyc, cap_n);
        end
    endtask

    task automatic check_frame(input string name, input int exp_err, input bit full_rate);
        n_checks++;
        if (cap_n !== N) begin
            n_fail++;
            $display("FAIL %s beat_count: got %0d exp %0d", name, cap_n, N);
        end
        for (int k = 0; k < N && k < cap_n; k++) begin
            n_checks++;
            if ({cap_last[k], cap_data[k]} !== {(k == N - 1), model_beat(k)}) begin
                n_fail++;
                $display("FAIL %s bin %0d: got last=%b data=%h exp last=%b data=%h",
                         name, k, cap_last[k], cap_data[k], (k == N - 1), model_beat(k));
            end
        end
        n_checks++;
        if (cap_cfg_cnt !== 1) begin
            n_fail++;
            $display("FAIL %s cfg_count: got %0d exp 1", name, cap_cfg_cnt);
        end
        n_checks++;
        if (cap_first !== cap_cfg_hs + 1) begin
            n_fail++;
            $display("FAIL %s first_beat_latency: got cyc %0d exp %0d", name, cap_first, cap_cfg_hs + 1);
        end
        n_checks++;
        if (cap_done !== cap_last_hs + 1) begin
            n_fail++;
            $display("FAIL %s frame_done_timing: got cyc %0d exp %0d", name, cap_done, cap_last_hs + 1);
        end
        if (full_rate) begin
            n_checks++;
            if (cap_last_hs - cap_first !== N - 1) begin
                n_fail++;
                $display("FAIL %s throughput: got span %0d exp %0d", name, cap_last_hs - cap_first, N - 1);
            end
        end
        n_checks++;
        if (cap_err_cnt !== exp_err) begin
            n_fail++;
            $display("FAIL %s tab_err_count: got %0d exp %0d", name, cap_err_cnt, exp_err);
        end
        if (exp_err > 0) begin
            n_checks++;
            if (cap_err_cyc !== cap_inj_cyc + 1) begin
                n_fail++;
                $display("FAIL %s tab_err_timing: got cyc %0d exp %0d", name, cap_err_cyc, cap_inj_cyc + 1);
            end
        end
        $display("frame %s: %0d beats, cfg@%0d first@%0d last@%0d done@%0d", name, cap_n,
                 cap_cfg_hs, cap_first, cap_last_hs, cap_done);
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0 || cfg_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after: got busy=%b m_tvalid=%b cfg_tvalid=%b exp 0 0 0",
                     name, busy, m_tvalid, cfg_tvalid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tab_err, cfg_tdata, cfg_tvalid, m_tdata, m_tvalid, m_tlast, busy, frame_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got err=%b cfg=%h cv=%b d=%h v=%b l=%b busy=%b done=%b exp all 0",
                     tab_err, cfg_tdata, cfg_tvalid, m_tdata, m_tvalid, m_tlast, busy, frame_done);
        end
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        $display("reset: outputs checked");
    endtask

    task automatic test_single_tone();
        write_entry(0, 1, 5, 1000, 0);
        do_start();
        capture_frame(100, 0, -1, -1);
        check_frame("tone", 0, 1'b1);
        check_idle("tone");
    endtask

    task automatic test_hermitian();
        do_reset();
        write_entry(0, 1, 3, 200, 50);
        do_start();
        capture_frame(100, 0, -1, -1);
        check_frame("hermitian", 0, 1'b1);
        check_idle("hermitian");
    endtask

    task automatic test_random_backpressure();
        for (int i = 0; i < NTAB; i++) begin
            int b;
            b = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, N - 1));
            write_entry(i, ($urandom_range(0, 3) != 0) ? 1 : 0, b,
                        int'($urandom_range(0, 4094)) - 2047, int'($urandom_range(0, 4094)) - 2047);
        end
        do_start();
        capture_frame(100, 0, -1, -1);
        check_frame("rand_full", 0, 1'b1);
        check_idle("rand_full");
        do_start();
        capture_frame(50, 0, -1, -1);
        check_frame("rand_bp50", 0, 1'b0);
        check_idle("rand_bp50");
    endtask

    task automatic test_busy_write();
        do_reset();
        write_entry(0, 1, 5, 1000, 0);
        inj_addr = 0; inj_bin = 100; inj_re = -321; inj_im = 77;
        do_start();
        capture_frame(100, 0, 100, -1);
        check_frame("busy_write", 1, 1'b1);
        check_idle("busy_write");
        write_entry(inj_addr, 1, inj_bin, inj_re, inj_im);
        // Write and start in the same idle cycle: the frame must see the new entry
        tab_addr = 3'd1; tab_en = 1'b1; tab_bin = 10'd7; tab_re = 12'(42); tab_im = 12'(-42);
        tab_we = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        tab_we = 1'b0;
        start  = 1'b0;
        m_en[1] = 1; m_bin[1] = 7; m_re[1] = 42; m_im[1] = -42;
        capture_frame(100, 0, -1, -1);
        check_frame("write_with_start", 0, 1'b1);
        check_idle("write_with_start");
    endtask

    task automatic test_continuous();
        write_entry(2, 1, 0, -5, 9);
        write_entry(3, 1, 900, 1234, -1234);
        continuous = 1'b1;
        do_start();
        capture_frame(100, 0, -1, -1);
        check_frame("cont_1", 0, 1'b1);
        cfg_tready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cfg_tvalid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_restart: got cfg_tvalid=%b busy=%b exp 1 1", cfg_tvalid, busy);
        end
        capture_frame(100, 10, -1, 512);
        check_frame("cont_2", 0, 1'b1);
        n_checks++;
        if (cap_cfg_hs !== 11) begin
            n_fail++;
            $display("FAIL cont_cfg_hold: got handshake cyc %0d exp 11", cap_cfg_hs);
        end
        check_idle("cont_2");
        continuous = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int cnt;
        int cyc;
        cnt = 0;
        cyc = 0;
        do_start();
        cfg_tready = 1'b1;
        m_tready   = 1'b1;
        while (cnt < 512 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (m_tvalid === 1'b1) cnt++;
        end
        n_checks++;
        if (cnt < 512) begin
            n_fail++;
            $display("FAIL midrst_reach: got %0d beats exp 512", cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        cfg_tready = 1'b0;
        m_tready   = 1'b0;
        @(negedge clk);
        n_checks++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0 || m_tlast !== 1'b0 || frame_done !== 1'b0 || m_tdata !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got v=%b busy=%b l=%b done=%b d=%h exp all 0",
                     m_tvalid, busy, m_tlast, frame_done, m_tdata);
        end
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        do_start();
        capture_frame(100, 0, -1, -1);
        check_frame("after_midrst", 0, 1'b1);
        check_idle("after_midrst");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; continuous = 1'b0; tab_we = 1'b0;
        tab_addr = '0; tab_en = 1'b0; tab_bin = '0; tab_re = '0; tab_im = '0;
        cfg_tready = 1'b0; m_tready = 1'b0;
        inj_addr = 0; inj_bin = 0; inj_re = 0; inj_im = 0;
        model_clear();

        test_reset();
        test_single_tone();
        test_hermitian();
        test_random_backpressure();
        test_busy_write();
        test_continuous();
        test_reset_mid_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
